// File: rtl/alu_issue_ctrl_pkg.sv
// alu_issue_ctrl_pkg: shared widths, ALU ctl codes, ALUOp and funct3 encodings
package alu_issue_ctrl_pkg;
  localparam int DEF_WORDSIZE = 32;
  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  typedef enum logic [1:0] {
    ALUOP_MEM = 2'b00,
    ALUOP_BR  = 2'b01,
    ALUOP_R   = 2'b10,
    ALUOP_RSV = 2'b11
  } aluop_e;
  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;
endpackage

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: request/response handshake bundle between sequencer (master) and issue ctrl (slave)
// req_*: operands + opcode fields with valid/ready; rsp_*: result/zero/illegal with valid/ready; busy: activity flag
interface alu_issue_ctrl_if #(parameter int WORDSIZE = alu_issue_ctrl_pkg::DEF_WORDSIZE);
  logic                req_valid;
  logic                req_ready;
  logic [WORDSIZE-1:0] req_a;
  logic [WORDSIZE-1:0] req_b;
  logic [1:0]          req_aluop;
  logic [2:0]          req_funct3;
  logic                req_funct7b5;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [WORDSIZE-1:0] rsp_result;
  logic                rsp_zero;
  logic                rsp_illegal;
  logic                busy;
  modport master (
    output req_valid, req_a, req_b, req_aluop, req_funct3, req_funct7b5, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_illegal, busy
  );
  modport slave (
    input  req_valid, req_a, req_b, req_aluop, req_funct3, req_funct7b5, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_illegal, busy
  );
endinterface

// File: rtl/alu.sv
// alu: combinational AND/OR/ADD/SUB selected by ctl, with zero flag
// in1/in2: operands; ctl: 4-bit op code; result: wrapped result; zero: result==0
module alu
  import alu_issue_ctrl_pkg::*;
#(
  parameter int WORDSIZE = DEF_WORDSIZE
) (
  input  logic [WORDSIZE-1:0] in1,
  input  logic [WORDSIZE-1:0] in2,
  input  logic [3:0]          ctl,
  output logic [WORDSIZE-1:0] result,
  output logic                zero
);
  always_comb begin
    result = ctl == CTL_AND ? in1 & in2 :
             ctl == CTL_OR  ? in1 | in2 :
             ctl == CTL_ADD ? in1 + in2 :
             ctl == CTL_SUB ? in1 - in2 : '0;
    zero   = result == '0;
  end
endmodule

// File: rtl/alu_issue_ctrl_alu_ctl_decode.sv
// alu_ctl_decode: maps ALUOp/funct3/funct7[5] to ALU ctl code and illegal flag
// aluop_i/funct3_i/funct7b5_i: instruction fields; ctl_o: ALU ctl; illegal_o: no legal mapping
module alu_ctl_decode
  import alu_issue_ctrl_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output logic [3:0] ctl_o,
  output logic       illegal_o
);
  logic r_ok;
  always_comb begin
    r_ok      = funct3_i == F3_ADDSUB || funct3_i == F3_AND || funct3_i == F3_OR;
    illegal_o = aluop_i == ALUOP_RSV || (aluop_i == ALUOP_R && !r_ok);
    ctl_o     = illegal_o               ? CTL_ADD :
                aluop_i == ALUOP_MEM    ? CTL_ADD :
                aluop_i == ALUOP_BR     ? CTL_SUB :
                funct3_i == F3_AND      ? CTL_AND :
                funct3_i == F3_OR       ? CTL_OR  :
                funct7b5_i              ? CTL_SUB : CTL_ADD;
  end
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: request FIFO + ctl decode + shared alu + registered valid/ready response
// clk: rising-edge clock; rst_n: synchronous active-low reset; bus: slave side of alu_issue_ctrl_if
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int WORDSIZE   = DEF_WORDSIZE,
  parameter int FIFO_DEPTH = 4
) (
  input logic            clk,
  input logic            rst_n,
  alu_issue_ctrl_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [WORDSIZE-1:0] a_q  [FIFO_DEPTH];
  logic [WORDSIZE-1:0] b_q  [FIFO_DEPTH];
  logic [1:0]          op_q [FIFO_DEPTH];
  logic [2:0]          f3_q [FIFO_DEPTH];
  logic                b5_q [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]         count_q, count_d;
  logic                rsp_valid_q, rsp_valid_d, rsp_zero_q, rsp_zero_d, rsp_illegal_q, rsp_illegal_d;
  logic [WORDSIZE-1:0] rsp_result_q, rsp_result_d, alu_res;
  logic                req_ready, head, push, pop, ill, alu_zero;
  logic [3:0]          ctl;
  alu_ctl_decode u_dec (
    .aluop_i    (op_q[rd_ptr_q]),
    .funct3_i   (f3_q[rd_ptr_q]),
    .funct7b5_i (b5_q[rd_ptr_q]),
    .ctl_o      (ctl),
    .illegal_o  (ill)
  );
  alu #(.WORDSIZE(WORDSIZE)) u_alu (
    .in1    (a_q[rd_ptr_q]),
    .in2    (b_q[rd_ptr_q]),
    .ctl    (ctl),
    .result (alu_res),
    .zero   (alu_zero)
  );
  // ready comes from the registered count only, so a full FIFO never admits a push even while popping
  always_comb begin
    req_ready     = count_q != (PW+1)'(FIFO_DEPTH);
    head          = count_q != '0;
    push          = bus.req_valid && req_ready;
    pop           = head && (!rsp_valid_q || bus.rsp_ready);
    wr_ptr_d      = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d      = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d       = count_q + (PW+1)'(push) - (PW+1)'(pop);
    rsp_valid_d   = pop || (rsp_valid_q && !bus.rsp_ready);
    rsp_result_d  = pop ? (ill ? '0 : alu_res) : rsp_result_q;
    rsp_zero_d    = pop ? (ill || alu_zero) : rsp_zero_q;
    rsp_illegal_d = pop ? ill : rsp_illegal_q;
  end
  always_ff @(posedge clk) begin
    if (push) begin
      a_q[wr_ptr_q]  <= bus.req_a;
      b_q[wr_ptr_q]  <= bus.req_b;
      op_q[wr_ptr_q] <= bus.req_aluop;
      f3_q[wr_ptr_q] <= bus.req_funct3;
      b5_q[wr_ptr_q] <= bus.req_funct7b5;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_zero_q    <= 1'b0;
      rsp_illegal_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_zero_q    <= rsp_zero_d;
      rsp_illegal_q <= rsp_illegal_d;
    end
  end
  assign bus.req_ready   = req_ready;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_zero    = rsp_zero_q;
  assign bus.rsp_illegal = rsp_illegal_q;
  assign bus.busy        = head || rsp_valid_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: scoreboard bench for alu_issue_ctrl with directed and random requests
module tb_alu_issue_ctrl;
  typedef struct packed {
    logic        ill;
    logic        zero;
    logic [31:0] res;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  bit rand_mode = 1'b0;
  exp_t exp_q[$];
  always #5 clk = ~clk;
  alu_issue_ctrl_if #(.WORDSIZE(32)) bus ();
  alu_issue_ctrl #(.WORDSIZE(32), .FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                                 input logic [2:0] f3, input logic b5);
    exp_t e;
    logic [31:0] r;
    logic il;
    il = 1'b0;
    r  = '0;
    case (op)
      2'b00: r = a + b;
      2'b01: r = a - b;
      2'b10: begin
        if (f3 == 3'b000) r = b5 ? a - b : a + b;
        else if (f3 == 3'b111) r = a & b;
        else if (f3 == 3'b110) r = a | b;
        else il = 1'b1;
      end
      default: il = 1'b1;
    endcase
    e.ill  = il;
    e.res  = il ? 32'h0 : r;
    e.zero = il ? 1'b1 : (r == 32'h0);
    return e;
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: got res=%h zero=%b ill=%b with no request pending",
                   bus.rsp_result, bus.rsp_zero, bus.rsp_illegal);
        end else begin
          e = exp_q.pop_front();
          if ({bus.rsp_illegal, bus.rsp_zero, bus.rsp_result} !== e) begin
            errors++;
            $display("FAIL rsp: got res=%h zero=%b ill=%b expected res=%h zero=%b ill=%b",
                     bus.rsp_result, bus.rsp_zero, bus.rsp_illegal, e.res, e.zero, e.ill);
          end
        end
      end
    end
  endtask
  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                      input logic [2:0] f3, input logic b5, input exp_t e);
    logic rdy;
    bus.req_valid    = 1'b1;
    bus.req_a        = a;
    bus.req_b        = b;
    bus.req_aluop    = op;
    bus.req_funct3   = f3;
    bus.req_funct7b5 = b5;
    for (int n = 0; n < 100; n++) begin
      if (rand_mode) bus.rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      rdy = bus.req_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        exp_q.push_back(e);
        bus.req_valid = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    bus.req_valid = 1'b0;
    $display("FAIL push_timeout: got req_ready=0 for 100 cycles expected acceptance");
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    logic [31:0] ra, rb;
    logic [1:0]  rop;
    logic [2:0]  rf3;
    logic        rb5;
    int          w;
    bus.req_valid    = 1'b0;
    bus.req_a        = '0;
    bus.req_b        = '0;
    bus.req_aluop    = '0;
    bus.req_funct3   = '0;
    bus.req_funct7b5 = 1'b0;
    bus.rsp_ready    = 1'b0;
    fork
      monitor();
    join_none
    idle(2);
    rst_n = 1'b1;
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_req_ready", 32'(bus.req_ready), 32'd1);
    check("reset_rsp_result", bus.rsp_result, 32'd0);
    check("reset_rsp_zero", 32'(bus.rsp_zero), 32'd0);
    bus.rsp_ready = 1'b1;
    push(32'd5, 32'd5, 2'b10, 3'b000, 1'b1, '{ill: 1'b0, zero: 1'b1, res: 32'h0});
    check("lat_edge1_valid", 32'(bus.rsp_valid), 32'd0);
    idle(1);
    check("lat_edge2_valid", 32'(bus.rsp_valid), 32'd1);
    idle(2);
    push(32'hF0F0F0F0, 32'h0FF00FF0, 2'b10, 3'b111, 1'b0, '{ill: 1'b0, zero: 1'b0, res: 32'h00F000F0});
    push(32'hF0F0F0F0, 32'h0FF00FF0, 2'b10, 3'b110, 1'b0, '{ill: 1'b0, zero: 1'b0, res: 32'hFFF0FFF0});
    push(32'hFFFFFFFF, 32'h00000001, 2'b00, 3'b000, 1'b0, '{ill: 1'b0, zero: 1'b1, res: 32'h0});
    push(32'd9, 32'd4, 2'b01, 3'b000, 1'b0, '{ill: 1'b0, zero: 1'b0, res: 32'd5});
    push(32'd7, 32'd3, 2'b11, 3'b000, 1'b0, '{ill: 1'b1, zero: 1'b1, res: 32'h0});
    push(32'd7, 32'd3, 2'b10, 3'b001, 1'b0, '{ill: 1'b1, zero: 1'b1, res: 32'h0});
    push(32'd2, 32'd3, 2'b10, 3'b000, 1'b0, '{ill: 1'b0, zero: 1'b0, res: 32'd5});
    idle(4);
    check("mix_drained", 32'(exp_q.size()), 32'd0);
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      push(32'(i), 32'd100, 2'b00, 3'b000, 1'b0, '{ill: 1'b0, zero: 1'b0, res: 32'(i + 100)});
    check("bp_req_ready_low", 32'(bus.req_ready), 32'd0);
    check("bp_busy", 32'(bus.busy), 32'd1);
    idle(3);
    check("bp_hold_result", bus.rsp_result, 32'd100);
    check("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
    bus.rsp_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("bp_one_per_cycle", 32'(exp_q.size()), 32'd0);
    idle(2);
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      push(32'(i), 32'd1, 2'b00, 3'b000, 1'b0, '{ill: 1'b0, zero: 1'b0, res: 32'(i + 1)});
    rst_n = 1'b0;
    exp_q.delete();
    idle(2);
    rst_n = 1'b1;
    check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_req_ready", 32'(bus.req_ready), 32'd1);
    bus.rsp_ready = 1'b1;
    idle(5);
    check("midrst_no_stale", 32'(bus.rsp_valid), 32'd0);
    rand_mode = 1'b1;
    for (int i = 0; i < 200; i++) begin
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      rop = 2'($urandom_range(0, 3));
      w   = $urandom_range(0, 4);
      rf3 = w == 0 ? 3'b111 : w == 1 ? 3'b110 : w == 2 ? 3'($urandom_range(0, 7)) : 3'b000;
      rb5 = 1'($urandom_range(0, 1));
      push(ra, rb, rop, rf3, rb5, model(ra, rb, rop, rf3, rb5));
      if ($urandom_range(0, 4) == 0) idle(1);
    end
    rand_mode = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) idle(1);
    check("final_drain", 32'(exp_q.size()), 32'd0);
    idle(2);
    check("final_idle_busy", 32'(bus.busy), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
